// File: rtl/dnn_feature_feeder_if.sv
// Feature-word ingress and DNN vec_in/dv_in egress signals of the feature feeder.
interface dnn_feature_feeder_if #(
    parameter int unsigned DATA_W = 20
);
    logic [DATA_W-1:0] feat_in;
    logic              feat_valid;
    logic              feat_ready;
    logic [DATA_W-1:0] dnn_vec;
    logic              dnn_dv;
    logic              frame_last;

    // master: MFCC front end / DNN side; slave: the feeder itself
    modport master (
        output feat_in, feat_valid,
        input  feat_ready, dnn_vec, dnn_dv, frame_last
    );
    modport slave (
        input  feat_in, feat_valid,
        output feat_ready, dnn_vec, dnn_dv, frame_last
    );
endinterface

// File: rtl/dnn_feature_feeder.sv
// Buffers MFCC feature words in a FIFO and issues them to the DNN as rate-limited
// single-cycle dv strobes, tagging the last word of every feature frame.
module dnn_feature_feeder #(
    parameter int unsigned DATA_W    = 20,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned GAP       = 21,
    parameter int unsigned FRAME_LEN = 39
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    dnn_feature_feeder_if.slave      bus,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     drop_err
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int unsigned IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic [IW-1:0]     widx_q, widx_d;
    logic [DATA_W-1:0] vec_q,  vec_d;
    logic              dv_q,   dv_d;
    logic              last_q, last_d;
    logic              drop_q, drop_d;

    logic full, empty, wr_en, rd_en, at_frame_end;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign wr_en = bus.feat_valid & ~full & ~flush & ~reset;
    assign rd_en = ~empty & (gcnt_q == '0) & ~flush;
    assign at_frame_end = (widx_q == IW'(FRAME_LEN - 1));

    // Next-state: flush wins over write and issue in the same cycle
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        gcnt_d = gcnt_q;
        widx_d = widx_q;
        vec_d  = vec_q;
        dv_d   = 1'b0;
        last_d = 1'b0;
        drop_d = drop_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            gcnt_d = '0;
            widx_d = '0;
            drop_d = 1'b0;
        end else begin
            if (wr_en) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (bus.feat_valid && full) begin
                drop_d = 1'b1;
            end
            if (rd_en) begin
                vec_d  = mem[rptr_q[AW-1:0]];
                dv_d   = 1'b1;
                rptr_d = rptr_q + PW'(1);
                gcnt_d = GW'(GAP - 1);
                last_d = at_frame_end;
                widx_d = at_frame_end ? '0 : widx_q + IW'(1);
            end else if (gcnt_q != '0) begin
                gcnt_d = gcnt_q - GW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            gcnt_q <= '0;
            widx_q <= '0;
            vec_q  <= '0;
            dv_q   <= 1'b0;
            last_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            gcnt_q <= gcnt_d;
            widx_q <= widx_d;
            vec_q  <= vec_d;
            dv_q   <= dv_d;
            last_q <= last_d;
            drop_q <= drop_d;
        end
    end

    // Storage array needs no reset; pointers define what is valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q[AW-1:0]] <= bus.feat_in;
        end
    end

    assign bus.feat_ready = ~full & ~reset;
    assign bus.dnn_vec    = vec_q;
    assign bus.dnn_dv     = dv_q;
    assign bus.frame_last = last_q;
    assign fill           = wptr_q - rptr_q;
    assign drop_err       = drop_q;
endmodule
